// File: rtl/dll_mq_pkg.sv
// Shared types and default configuration for the multi-queue linked-list engine.
package dll_mq_pkg;

  localparam int unsigned DEF_ID_N  = 4;
  localparam int unsigned DEF_PTR_N = 256;
  localparam int unsigned DEF_W     = 32;

  // Widths derived from the default configuration
  localparam int unsigned PTR_W = $clog2(DEF_PTR_N);
  localparam int unsigned ID_W  = $clog2(DEF_ID_N);
  localparam int unsigned CNT_W = $clog2(DEF_PTR_N + 1);

  typedef enum logic [2:0] {
    OP_POP_FRONT  = 3'b000,
    OP_POP_BACK   = 3'b001,
    OP_PUSH_FRONT = 3'b010,
    OP_PUSH_BACK  = 3'b011,
    OP_DELETE     = 3'b100
  } op_t;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
  } queue_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/dll_mq_ffs.sv
// Find-first-zero: lowest index whose bit is clear, plus a none-found flag.
module dll_mq_ffs #(
  parameter  int unsigned N  = 256,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // Scan upward, latching the first clear bit
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (none_o && !vec_i[i]) begin
        idx_o  = IW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dll_mq.sv
// Multi-queue doubly linked list engine over a shared node pool.
module dll_mq
  import dll_mq_pkg::*;
#(
  parameter  int unsigned ID_N  = DEF_ID_N,
  parameter  int unsigned PTR_N = DEF_PTR_N,
  parameter  int unsigned W     = DEF_W,
  localparam int unsigned PW    = $clog2(PTR_N),
  localparam int unsigned IW    = (ID_N > 1) ? $clog2(ID_N) : 1,
  localparam int unsigned CW    = $clog2(PTR_N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic [2:0]         cmd_op,
  input  logic [IW-1:0]      cmd_id,
  input  logic [PW-1:0]      cmd_ptr,
  input  logic [W-1:0]       cmd_data,
  output logic               resp_vld,
  output logic               resp_err,
  output logic [PW-1:0]      resp_ptr,
  output logic [W-1:0]       resp_data,
  output logic [ID_N-1:0]    empty,
  output logic               full,
  output logic [ID_N*CW-1:0] cnt
);

  state_t state_q, state_d;

  // Captured command
  logic [2:0]    op_q;
  logic [IW-1:0] id_q;
  logic [PW-1:0] ptr_q;
  logic [W-1:0]  wdata_q;

  // Node pool
  logic [PW-1:0] nxt_q [PTR_N];
  logic [PW-1:0] prv_q [PTR_N];
  logic [IW-1:0] own_q [PTR_N];
  logic [W-1:0]  dat_q [PTR_N];
  logic [PTR_N-1:0] alloc_q;

  // Queue table
  logic [ID_N-1:0] valid_q;
  logic [PW-1:0]   head_q [ID_N];
  logic [PW-1:0]   tail_q [ID_N];
  logic [CW-1:0]   qcnt_q [ID_N];

  // Response registers
  logic          resp_vld_q, resp_err_q;
  logic [PW-1:0] resp_ptr_q;
  logic [W-1:0]  resp_data_q;

  // Allocator
  logic [PW-1:0] free_idx;
  logic          pool_full;

  dll_mq_ffs #(.N(PTR_N)) u_ffs (
    .vec_i  (alloc_q),
    .idx_o  (free_idx),
    .none_o (pool_full)
  );

  // Execute-stage decode
  logic          exec, id_ok, err, commit;
  logic          cur_valid;
  logic [PW-1:0] cur_head, cur_tail, tgt;
  logic [CW-1:0] cur_cnt;
  logic [PW-1:0] rptr;
  logic [W-1:0]  rdata;
  logic          nxt_we, prv_we, node_we, free_we;
  logic [PW-1:0] nxt_wa, nxt_wd, prv_wa, prv_wd;
  logic          qv_d;
  logic [PW-1:0] qh_d, qt_d;
  logic [CW-1:0] qc_d;

  assign exec      = (state_q == ST_EXEC);
  assign id_ok     = (32'(id_q) < ID_N);
  assign cur_valid = valid_q[id_q];
  assign cur_head  = head_q[id_q];
  assign cur_tail  = tail_q[id_q];
  assign cur_cnt   = qcnt_q[id_q];
  assign commit    = exec && !err;

  // FSM next state and handshake
  always_comb begin
    state_d = state_q;
    cmd_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Compute the table updates and response for the captured command.
  // End pointers (prev of head, next of tail) are never dereferenced, so a
  // delete only rewrites the neighbour links that actually exist.
  always_comb begin
    err     = 1'b1;
    tgt     = '0;
    rptr    = '0;
    rdata   = '0;
    nxt_we  = 1'b0;
    nxt_wa  = '0;
    nxt_wd  = '0;
    prv_we  = 1'b0;
    prv_wa  = '0;
    prv_wd  = '0;
    node_we = 1'b0;
    free_we = 1'b0;
    qv_d    = cur_valid;
    qh_d    = cur_head;
    qt_d    = cur_tail;
    qc_d    = cur_cnt;
    if (id_ok) begin
      case (op_q)
        OP_POP_FRONT, OP_POP_BACK: begin
          if (cur_valid) begin
            err     = 1'b0;
            tgt     = (op_q == OP_POP_FRONT) ? cur_head : cur_tail;
            rptr    = tgt;
            rdata   = dat_q[tgt];
            free_we = 1'b1;
            qc_d    = cur_cnt - CW'(1);
            if (cur_cnt == CW'(1)) qv_d = 1'b0;
            else if (op_q == OP_POP_FRONT) qh_d = nxt_q[tgt];
            else qt_d = prv_q[tgt];
          end
        end
        OP_PUSH_FRONT, OP_PUSH_BACK: begin
          if (!pool_full) begin
            err     = 1'b0;
            tgt     = free_idx;
            rptr    = free_idx;
            node_we = 1'b1;
            nxt_we  = 1'b1;
            prv_we  = 1'b1;
            qc_d    = cur_cnt + CW'(1);
            if (!cur_valid) begin
              qv_d   = 1'b1;
              qh_d   = free_idx;
              qt_d   = free_idx;
              nxt_wa = free_idx;
              nxt_wd = free_idx;
              prv_wa = free_idx;
              prv_wd = free_idx;
            end else if (op_q == OP_PUSH_FRONT) begin
              qh_d   = free_idx;
              nxt_wa = free_idx;
              nxt_wd = cur_head;
              prv_wa = cur_head;
              prv_wd = free_idx;
            end else begin
              qt_d   = free_idx;
              nxt_wa = cur_tail;
              nxt_wd = free_idx;
              prv_wa = free_idx;
              prv_wd = cur_tail;
            end
          end
        end
        OP_DELETE: begin
          if (alloc_q[ptr_q] && (own_q[ptr_q] == id_q)) begin
            err     = 1'b0;
            tgt     = ptr_q;
            rptr    = ptr_q;
            rdata   = dat_q[ptr_q];
            free_we = 1'b1;
            qc_d    = cur_cnt - CW'(1);
            if (cur_cnt == CW'(1)) begin
              qv_d = 1'b0;
            end else begin
              if (ptr_q == cur_head) begin
                qh_d = nxt_q[ptr_q];
              end else begin
                nxt_we = 1'b1;
                nxt_wa = prv_q[ptr_q];
                nxt_wd = nxt_q[ptr_q];
              end
              if (ptr_q == cur_tail) begin
                qt_d = prv_q[ptr_q];
              end else begin
                prv_we = 1'b1;
                prv_wa = nxt_q[ptr_q];
                prv_wd = prv_q[ptr_q];
              end
            end
          end
        end
        default: err = 1'b1;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Command capture on acceptance
  always_ff @(posedge clk) begin
    if (cmd_rdy && cmd_vld) begin
      op_q    <= cmd_op;
      id_q    <= cmd_id;
      ptr_q   <= cmd_ptr;
      wdata_q <= cmd_data;
    end
  end

  // Link, owner and data arrays (not reset)
  always_ff @(posedge clk) begin
    if (commit) begin
      if (nxt_we) nxt_q[nxt_wa] <= nxt_wd;
      if (prv_we) prv_q[prv_wa] <= prv_wd;
      if (node_we) begin
        dat_q[free_idx] <= wdata_q;
        own_q[free_idx] <= id_q;
      end
    end
  end

  // Allocation bitmap and queue table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < ID_N; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        qcnt_q[i] <= '0;
      end
    end else if (commit) begin
      if (node_we) alloc_q[tgt] <= 1'b1;
      if (free_we) alloc_q[tgt] <= 1'b0;
      valid_q[id_q] <= qv_d;
      head_q[id_q]  <= qh_d;
      tail_q[id_q]  <= qt_d;
      qcnt_q[id_q]  <= qc_d;
    end
  end

  // Response registers, strobed for one cycle after execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_ptr_q  <= '0;
      resp_data_q <= '0;
    end else begin
      resp_vld_q <= exec;
      if (exec) begin
        resp_err_q  <= err;
        resp_ptr_q  <= err ? '0 : rptr;
        resp_data_q <= err ? '0 : rdata;
      end
    end
  end

  // Flatten per-queue occupancy
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < ID_N; i++) cnt[i*CW +: CW] = qcnt_q[i];
  end

  assign resp_vld  = resp_vld_q;
  assign resp_err  = resp_err_q;
  assign resp_ptr  = resp_ptr_q;
  assign resp_data = resp_data_q;
  assign empty     = ~valid_q;
  assign full      = &alloc_q;

endmodule

// File: tb/tb_dll_mq.sv
// Self-checking bench for dll_mq against a queue-level reference model.
module tb_dll_mq;

  localparam int NQ = 4;
  localparam int NP = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_id;
  logic [7:0]  cmd_ptr;
  logic [31:0] cmd_data;
  logic        resp_vld;
  logic        resp_err;
  logic [7:0]  resp_ptr;
  logic [31:0] resp_data;
  logic [3:0]  empty;
  logic        full;
  logic [35:0] cnt;

  dll_mq #(.ID_N(NQ), .PTR_N(NP), .W(32)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_ptr(cmd_ptr), .cmd_data(cmd_data),
    .resp_vld(resp_vld), .resp_err(resp_err), .resp_ptr(resp_ptr),
    .resp_data(resp_data), .empty(empty), .full(full), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each queue is a list of node indices
  int          mq [NQ][$];
  logic [31:0] mdata [NP];
  bit          malloc [NP];
  int          mown [NP];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    for (int i = 0; i < NP; i++) malloc[i] = 0;
  endtask

  task automatic model(input int op, input int id, input int ptr, input logic [31:0] d,
                       output bit e, output int p, output logic [31:0] dd);
    e = 1; p = 0; dd = '0;
    case (op)
      0, 1: if (mq[id].size() > 0) begin
        e = 0;
        p = (op == 0) ? mq[id].pop_front() : mq[id].pop_back();
        dd = mdata[p];
        malloc[p] = 0;
      end
      2, 3: begin
        int n;
        n = -1;
        for (int i = 0; i < NP; i++) if (!malloc[i]) begin n = i; break; end
        if (n >= 0) begin
          e = 0; p = n;
          malloc[n] = 1; mdata[n] = d; mown[n] = id;
          if (op == 2) mq[id].push_front(n); else mq[id].push_back(n);
        end
      end
      4: if (malloc[ptr] && mown[ptr] == id) begin
        e = 0; p = ptr; dd = mdata[ptr]; malloc[ptr] = 0;
        for (int i = 0; i < mq[id].size(); i++)
          if (mq[id][i] == ptr) begin mq[id].delete(i); break; end
      end
      default: e = 1;
    endcase
  endtask

  task automatic check_status(input string tag);
    logic [35:0] ec;
    logic [3:0]  ee;
    bit          ef;
    ec = '0; ee = '0; ef = 1;
    for (int i = 0; i < NQ; i++) begin
      ec[i*9 +: 9] = 9'(mq[i].size());
      ee[i] = (mq[i].size() == 0);
    end
    for (int i = 0; i < NP; i++) if (!malloc[i]) ef = 0;
    chk({tag, ".cnt"}, 64'(cnt), 64'(ec));
    chk({tag, ".empty"}, 64'(empty), 64'(ee));
    chk({tag, ".full"}, 64'(full), 64'(ef));
  endtask

  // Issue one command from a negedge and check its response two cycles later
  task automatic do_cmd(input int op, input int id, input int ptr, input logic [31:0] d,
                        output logic ge, output logic [7:0] gp, output logic [31:0] gd);
    int lat;
    bit e; int p; logic [31:0] dd;
    logic [7:0] p8;
    logic [1:0] i2;
    lat = 0;
    while (!cmd_rdy && lat < 10) begin @(negedge clk); lat++; end
    chk("rdy_before", 64'(cmd_rdy), 64'd1);
    p8 = 8'(ptr); i2 = 2'(id);
    cmd_vld = 1'b1; cmd_op = 3'(op); cmd_id = i2; cmd_ptr = p8; cmd_data = d;
    model(op, id, ptr, d, e, p, dd);
    @(posedge clk);
    #1 cmd_vld = 1'b0;
    cmd_data = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_vld && lat < 8);
    chk("latency", 64'(lat), 64'd2);
    chk("resp_vld", 64'(resp_vld), 64'd1);
    chk("rdy_with_resp", 64'(cmd_rdy), 64'd1);
    chk("resp_err", 64'(resp_err), 64'(e));
    if (!e) chk("resp_ptr", 64'(resp_ptr), 64'(p));
    chk("resp_data", 64'(resp_data), 64'(dd));
    check_status("cmd");
    ge = resp_err; gp = resp_ptr; gd = resp_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic e; logic [7:0] gp; logic [31:0] gd;
    int op, id, ptr, r;
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = '0; cmd_id = '0; cmd_ptr = '0; cmd_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst.cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("rst.resp_vld", 64'(resp_vld), 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.resp_ptr", 64'(resp_ptr), 64'd0);
    chk("rst.resp_data", 64'(resp_data), 64'd0);
    chk("rst.empty", 64'(empty), 64'hF);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.cnt", 64'(cnt), 64'd0);

    // Push back A,B,C into q0
    do_cmd(3, 0, 0, 32'hA, e, gp, gd); chk("pb0.ptr", 64'(gp), 64'd0);
    do_cmd(3, 0, 0, 32'hB, e, gp, gd); chk("pb1.ptr", 64'(gp), 64'd1);
    do_cmd(3, 0, 0, 32'hC, e, gp, gd); chk("pb2.ptr", 64'(gp), 64'd2);
    chk("q0.cnt3", 64'(cnt[8:0]), 64'd3);
    chk("q0.empty", 64'(empty), 64'b1110);

    // Push front then pop both ends
    do_cmd(2, 0, 0, 32'hD, e, gp, gd);
    do_cmd(0, 0, 0, 0, e, gp, gd);
    chk("pf.data", 64'(gd), 64'hD); chk("pf.ptr", 64'(gp), 64'd3);
    do_cmd(1, 0, 0, 0, e, gp, gd);
    chk("pbk.data", 64'(gd), 64'hC); chk("pbk.ptr", 64'(gp), 64'd2);

    // Delete from the middle of q1
    do_cmd(3, 1, 0, 32'h10, e, gp, gd);
    do_cmd(3, 1, 0, 32'h11, e, gp, gd); ptr = int'(gp);
    do_cmd(3, 1, 0, 32'h12, e, gp, gd);
    do_cmd(4, 1, ptr, 0, e, gp, gd); chk("del.data", 64'(gd), 64'h11);
    do_cmd(0, 1, 0, 0, e, gp, gd); chk("q1.pop0", 64'(gd), 64'h10);
    do_cmd(0, 1, 0, 0, e, gp, gd); chk("q1.pop1", 64'(gd), 64'h12);
    chk("q1.empty", 64'(empty[1]), 64'd1);

    // Error cases
    do_cmd(3, 1, 0, 32'h20, e, gp, gd); ptr = int'(gp);
    do_cmd(4, 2, ptr, 0, e, gp, gd); chk("err.wrong_owner", 64'(e), 64'd1);
    do_cmd(4, 0, 100, 0, e, gp, gd); chk("err.free_ptr", 64'(e), 64'd1);
    do_cmd(0, 3, 0, 0, e, gp, gd); chk("err.pop_empty", 64'(e), 64'd1);
    do_cmd(5, 0, 0, 0, e, gp, gd); chk("err.op5", 64'(e), 64'd1);
    do_cmd(7, 2, 0, 0, e, gp, gd); chk("err.op7", 64'(e), 64'd1);

    // Randomised mix
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 9));
      id = int'($urandom_range(0, NQ - 1));
      ptr = int'($urandom_range(0, NP - 1));
      case (r)
        0, 1: op = r;
        2, 3, 4, 5: op = 2 + (r & 1);
        6, 7: begin
          op = 4;
          if (mq[id].size() > 0) ptr = mq[id][$urandom_range(0, mq[id].size() - 1)];
        end
        8: op = int'($urandom_range(5, 7));
        default: op = 4;
      endcase
      do_cmd(op, id, ptr, $urandom, e, gp, gd);
    end

    // Fill the pool evenly, overflow, then reuse a freed node
    do_reset();
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 64; k++) do_cmd(3, q, 0, $urandom, e, gp, gd);
    chk("fill.full", 64'(full), 64'd1);
    do_cmd(3, 0, 0, 32'h5A5A, e, gp, gd); chk("fill.overflow", 64'(e), 64'd1);
    do_cmd(0, 2, 0, 0, e, gp, gd); chk("fill.pop_ptr", 64'(gp), 64'd128);
    do_cmd(3, 1, 0, 32'h77, e, gp, gd); chk("fill.reuse_ptr", 64'(gp), 64'd128);

    // Whole pool in one queue
    do_reset();
    for (int k = 0; k < NP; k++) do_cmd(r & 1 ? 2 : 3, 0, 0, $urandom, e, gp, gd);
    chk("one.cnt256", 64'(cnt[8:0]), 64'd256);
    chk("one.full", 64'(full), 64'd1);
    for (int k = 0; k < 8; k++) do_cmd(4, 0, int'($urandom_range(0, NP - 1)), 0, e, gp, gd);

    // Reset while a push is executing
    do_cmd(3, 3, 0, 32'h99, e, gp, gd);
    cmd_vld = 1'b1; cmd_op = 3'd3; cmd_id = 2'd1; cmd_data = 32'hBEEF;
    @(posedge clk);
    #1 cmd_vld = 1'b0; rst = 1'b1;
    @(negedge clk); chk("rexec.vld0", 64'(resp_vld), 64'd0);
    @(negedge clk); chk("rexec.vld1", 64'(resp_vld), 64'd0);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("rexec.no_resp", 64'(resp_vld), 64'd0);
    end
    chk("rexec.cnt", 64'(cnt), 64'd0);
    chk("rexec.empty", 64'(empty), 64'hF);
    do_cmd(3, 1, 0, 32'h1, e, gp, gd); chk("rexec.ptr0", 64'(gp), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dll_mq.md
# dll_mq

Parametrised multi-queue doubly linked list engine. It stores up to `PTR_N` data words in a shared node pool and threads them into `ID_N` independent deques. It supports push and pop at either end, plus a new delete-by-pointer operation that unlinks an arbitrary node. It sits behind a command/response handshake as the queue-management core for schedulers and reorder logic.

## Interface
- `ID_N`, default 4: number of queues.
- `PTR_N`, default 256: node pool depth; must be a power of two, ≥ 4.
- `W`, default 32: data word width.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: engine idle; accepts a command.
- `cmd_op` in 3: 000 POP_FRONT, 001 POP_BACK, 010 PUSH_FRONT, 011 PUSH_BACK, 100 DELETE; 101–111 illegal.
- `cmd_id` in clog2(ID_N): target queue.
- `cmd_ptr` in clog2(PTR_N): node to delete; DELETE only.
- `cmd_data` in W: word to push.
- `resp_vld` out 1: one-cycle response strobe; no backpressure.
- `resp_err` out 1: command rejected; state unchanged.
- `resp_ptr` out clog2(PTR_N): node allocated (push) or freed (pop/delete).
- `resp_data` out W: word removed (pop/delete); 0 on push or error.
- `empty` out ID_N: per-queue empty flag.
- `full` out 1: no free node.
- `cnt` out ID_N×clog2(PTR_N+1): per-queue occupancy, flattened; queue i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Per-node state: `next`, `prev`, `owner` id, `data`, `alloc` bit. Per-queue state: `valid`, `head`, `tail`, `cnt`.
- Allocation: the lowest-index free node (`alloc`=0) is chosen via find-first-zero.
- PUSH_FRONT/BACK:
  - Allocate node n; write data and set owner = id.
  - Link n at head or tail. On an empty queue, head = tail = n, with prev/next self-pointing.
  - `cnt`++.
- POP_FRONT/BACK:
  - Take head or tail. Return its ptr and data.
  - Advance head to `next[head]`, or tail to `prev[tail]`. If `cnt` was 1, set `valid`=0.
  - Free the node; `cnt`--.
- DELETE:
  - Node p is unlinked: `next[prev[p]]` = `next[p]` and `prev[next[p]]` = `prev[p]`.
  - If p is head or tail, that end pointer is updated. If p is the sole node, the queue becomes empty.
  - p is freed; `cnt`--.
- Errors set `resp_err`=1 and leave all state unchanged:
  - pop on an empty queue;
  - push while `full`;
  - DELETE where `alloc[p]`=0 or `owner[p]` ≠ `cmd_id`;
  - illegal opcode;
  - `cmd_id` ≥ ID_N.
- Widths:
  - `cnt` is CNT_W = clog2(PTR_N+1) bits, so it holds PTR_N exactly with no wrap.
  - The sum of all `cnt` values equals the number of set `alloc` bits at all times.
- `empty[i]` = ~`valid[i]`. `full` = &`alloc`. Both are derived from registered state.

## Timing
- FSM states:
  - IDLE: `cmd_rdy`=1. On `cmd_vld`, capture the command and go to EXEC.
  - EXEC: `cmd_rdy`=0. Compute updates from the captured command, commit them at the cycle-end edge, register the response, and return to IDLE.
- Latency:
  - Command accepted at edge N.
  - Tables updated and `resp_vld` high in cycle N+2, one cycle wide.
  - `cmd_rdy` high again in cycle N+2. Sustained throughput is 1 command per 2 cycles.
- Status outputs (`empty`, `full`, `cnt`) reflect the commit in the same cycle that `resp_vld` is high.
- Reset values:
  - `cmd_rdy`=1, `resp_vld`=0, `resp_err`=0, `resp_ptr`=0, `resp_data`=0.
  - `empty`=all ones, `full`=0, `cnt`=0.
  - All `alloc` bits cleared, all queues invalid.
  - Next/prev/data arrays are not reset.
- Reset asserted during EXEC drops the command: no response, no partial update.

## Structure
- `dll_mq_pkg` holds:
  - parameter-derived widths (`PTR_W`, `ID_W`, `CNT_W`);
  - the `op_t` enum, 3 bits;
  - the `queue_t` struct (valid, head, tail, cnt);
  - the FSM state enum.
- Sub-module `dll_mq_ffs`: parametrised find-first-zero over `alloc` (PTR_N in, index + none-found out), used for allocation.

## Test plan
- Reset, then PUSH_BACK q0 data 0xA, 0xB, 0xC -> `resp_ptr` 0,1,2; `cnt[0]`=3; `empty`=4'b1110.
- From that state, PUSH_FRONT q0 0xD then POP_FRONT q0 -> returns 0xD, ptr 3. Then POP_BACK q0 -> returns 0xC, ptr 2.
- PUSH_BACK q1 0x10,0x11,0x12, then DELETE q1 ptr of 0x11 -> data 0x11. Then POP_FRONT ×2 -> 0x10, 0x12; `empty[1]`=1.
- DELETE q2 with a ptr owned by q1, DELETE of a free ptr, and POP on empty q3 -> each `resp_err`=1; `cnt`/`empty` unchanged.
- Fill all 256 nodes across q0–q3 (64 each) -> `full`=1; 257th push errors. One pop, then one push -> reuses the freed ptr. With 256 nodes in one queue, `cnt` reads 256.
- Assert `rst` in the EXEC cycle of a PUSH -> no `resp_vld`. After release, `cnt`=0 and the next push gets ptr 0.
